aes128_block_loader: RTL

Byte-serial front end for the combinational `aes128` encryption core. It packs an 8-bit stream of key bytes and plaintext bytes into 128-bit words, snapshots the active key with each completed plaintext block, and presents {plaintext, key} pairs to the core under a valid/ready handshake. It sits directly upstream of the core's `plaintext`/`key` inputs; its outputs connect to the core with no logic in between.

---
 rtl/aes_pkg.sv | 6 +
 rtl/aes128_byte_packer.sv | 31 +++
 rtl/aes128_block_loader.sv | 97 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: block geometry shared by the AES-128 core and its front-end stages.
package aes_pkg;
    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W = 128;
    typedef logic [BLOCK_W-1:0] aes_block_t;
endpackage

// File: rtl/aes128_byte_packer.sv
// aes128_byte_packer: shifts bytes MSB-first into a 128-bit word and flags the 16th byte.
module aes128_byte_packer
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       clear,
    input  logic [7:0] din,
    output logic       done,
    output aes_block_t word
);
    logic [3:0] cnt_q, cnt_d;
    aes_block_t word_q, word_d;
    // word shows the completed group in the load cycle, the held register otherwise
    always_comb begin
        word_d = load ? {word_q[BLOCK_W-9:0], din} : word_q;
        cnt_d  = clear ? 4'd0 : load ? cnt_q + 4'd1 : cnt_q;
        done   = load && (cnt_q == 4'(BLOCK_BYTES - 1));
        word   = word_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 4'd0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/aes128_block_loader.sv
// aes128_block_loader: packs key/plaintext byte streams into {plaintext, key} blocks
// for the combinational aes128 core behind a valid/ready handshake.
module aes128_block_loader
    import aes_pkg::*;
#(
    parameter bit KEY_REQUIRED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_is_key,
    input  logic       in_flush,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_block_t out_plaintext,
    output aes_block_t out_key,
    output logic       err_nokey,
    output logic       key_loaded
);
    logic acc, k_load, d_acc, drop, d_load, k_done, d_done, out_free;
    aes_block_t k_word, d_word;
    logic out_valid_q, out_valid_d, asm_full_q, asm_full_d;
    logic err_q, err_d, key_loaded_q, key_loaded_d;
    aes_block_t key_q, key_d, park_key_q, park_key_d;
    aes_block_t out_pt_q, out_pt_d, out_key_q, out_key_d;

    aes128_byte_packer u_key (
        .clk(clk), .rst(rst), .load(k_load), .clear(in_flush),
        .din(in_data), .done(k_done), .word(k_word)
    );
    aes128_byte_packer u_data (
        .clk(clk), .rst(rst), .load(d_load), .clear(in_flush),
        .din(in_data), .done(d_done), .word(d_word)
    );

    always_comb begin
        acc          = in_valid && !asm_full_q && !in_flush;
        k_load       = acc && in_is_key;
        d_acc        = acc && !in_is_key;
        drop         = d_acc && KEY_REQUIRED && !key_loaded_q;
        d_load       = d_acc && !drop;
        out_free     = !out_valid_q || out_ready;
        out_valid_d  = out_valid_q && !out_ready;
        out_pt_d     = out_pt_q;
        out_key_d    = out_key_q;
        asm_full_d   = asm_full_q;
        park_key_d   = park_key_q;
        // a parked block keeps the key that was active when it completed
        if (asm_full_q && out_free) begin
            out_valid_d = 1'b1;
            out_pt_d    = d_word;
            out_key_d   = park_key_q;
            asm_full_d  = 1'b0;
        end else if (d_done && out_free) begin
            out_valid_d = 1'b1;
            out_pt_d    = d_word;
            out_key_d   = key_q;
        end else if (d_done) begin
            asm_full_d  = 1'b1;
            park_key_d  = key_q;
        end
        key_d        = k_done ? k_word : key_q;
        key_loaded_d = key_loaded_q || k_done;
        err_d        = drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            asm_full_q   <= 1'b0;
            err_q        <= 1'b0;
            key_loaded_q <= 1'b0;
            key_q        <= '0;
            park_key_q   <= '0;
            out_pt_q     <= '0;
            out_key_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            asm_full_q   <= asm_full_d;
            err_q        <= err_d;
            key_loaded_q <= key_loaded_d;
            key_q        <= key_d;
            park_key_q   <= park_key_d;
            out_pt_q     <= out_pt_d;
            out_key_q    <= out_key_d;
        end
    end

    assign in_ready      = !asm_full_q;
    assign out_valid     = out_valid_q;
    assign out_plaintext = out_pt_q;
    assign out_key       = out_key_q;
    assign err_nokey     = err_q;
    assign key_loaded    = key_loaded_q;
endmodule
